// File: rtl/fetch_if.sv
// F->D bundle between the fetch stage and its environment (hazard unit,
// execute redirect, instruction ROM and the decode stage).
interface fetch_if;
  logic        StallF_i;
  logic        StallD_i;
  logic        FlushD_i;
  logic        PCSrcE_i;
  logic [31:0] PCTargetE_i;
  logic [31:0] ImemData_i;
  logic [31:0] ImemAddr_o;
  logic [31:0] PCF_o;
  logic [31:0] InstrD_o;
  logic [31:0] PCD_o;
  logic [31:0] PCPlus4D_o;
  logic        ValidD_o;
  logic        MisalignF_o;

  // Fetch stage side: drives the PC, ROM address and IF/ID contents.
  modport master (
    input  StallF_i, StallD_i, FlushD_i, PCSrcE_i, PCTargetE_i, ImemData_i,
    output ImemAddr_o, PCF_o, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o, MisalignF_o
  );

  // Environment side: hazard unit, execute, ROM and decode.
  modport slave (
    output StallF_i, StallD_i, FlushD_i, PCSrcE_i, PCTargetE_i, ImemData_i,
    input  ImemAddr_o, PCF_o, InstrD_o, PCD_o, PCPlus4D_o, ValidD_o, MisalignF_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the RV32I pipeline: program counter, ROM address
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  logic [31:0] pcf_reg, pcf_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pcd_reg, pcd_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] pcf_plus4;

  // Sequential PC increment wraps naturally at 2^32.
  assign pcf_plus4 = pcf_reg + 32'd4;

  // PC next state: redirect beats stall; the target is forced word-aligned.
  always_comb begin
    pcf_next = pcf_plus4;
    if (bus.PCSrcE_i)
      pcf_next = {bus.PCTargetE_i[31:2], 2'b00};
    else if (bus.StallF_i)
      pcf_next = pcf_reg;
  end

  // IF/ID next state: flush inserts a bubble (and beats stall), stall holds.
  always_comb begin
    instr_next = bus.ImemData_i;
    pcd_next   = pcf_reg;
    pc4_next   = pcf_plus4;
    valid_next = 1'b1;
    if (bus.FlushD_i) begin
      instr_next = NOP_INSTR;
      pcd_next   = 32'd0;
      pc4_next   = 32'd0;
      valid_next = 1'b0;
    end else if (bus.StallD_i) begin
      instr_next = instr_reg;
      pcd_next   = pcd_reg;
      pc4_next   = pc4_reg;
      valid_next = valid_reg;
    end
  end

  // Sticky flag for any redirect whose target had low address bits set.
  always_comb begin
    misalign_next = misalign_reg;
    if (bus.PCSrcE_i && (bus.PCTargetE_i[1:0] != 2'b00))
      misalign_next = 1'b1;
  end

  // State registers; reset overrides every stall/flush/redirect input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_reg      <= RESET_PC;
      instr_reg    <= NOP_INSTR;
      pcd_reg      <= 32'd0;
      pc4_reg      <= 32'd0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      pcf_reg      <= pcf_next;
      instr_reg    <= instr_next;
      pcd_reg      <= pcd_next;
      pc4_reg      <= pc4_next;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
    end
  end

  assign bus.ImemAddr_o  = pcf_reg;
  assign bus.PCF_o       = pcf_reg;
  assign bus.InstrD_o    = instr_reg;
  assign bus.PCD_o       = pcd_reg;
  assign bus.PCPlus4D_o  = pc4_reg;
  assign bus.ValidD_o    = valid_reg;
  assign bus.MisalignF_o = misalign_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run, all checked against a rule-level reference model of the fetch stage.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction ROM contents as a pure function of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.ImemData_i = rom_word(bus.ImemAddr_o);

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid, m_mis;

  function automatic logic [161:0] expected();
    return {m_pc, m_pc, m_instr, m_pcd, m_pc4, m_valid, m_mis};
  endfunction

  function automatic logic [161:0] observed();
    return {bus.PCF_o, bus.ImemAddr_o, bus.InstrD_o, bus.PCD_o,
            bus.PCPlus4D_o, bus.ValidD_o, bus.MisalignF_o};
  endfunction

  // Apply one cycle of inputs, advance the model by the stage's rules and
  // leave the bench 1 time unit after the rising edge.
  task automatic step(input bit r, input bit sf, input bit sd, input bit fl,
                      input bit src, input logic [31:0] tgt);
    @(negedge clk);
    rst             = r;
    bus.StallF_i    = sf;
    bus.StallD_i    = sd;
    bus.FlushD_i    = fl;
    bus.PCSrcE_i    = src;
    bus.PCTargetE_i = tgt;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
    end else begin
      if (fl) begin
        m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
      end else if (!sd) begin
        m_instr = rom_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
      end
      if (src && (tgt % 4 != 0)) m_mis = 1;
      if (src)      m_pc = tgt - (tgt % 4);
      else if (!sf) m_pc = m_pc + 4;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h80);
    total++;
    if (bus.ImemAddr_o !== 32'h0 || bus.InstrD_o !== NOP || bus.ValidD_o !== 1'b0 ||
        bus.PCD_o !== 32'h0 || bus.PCPlus4D_o !== 32'h0 || bus.MisalignF_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got addr=%h instr=%h pcd=%h pc4=%h v=%b mis=%b",
               bus.ImemAddr_o, bus.InstrD_o, bus.PCD_o, bus.PCPlus4D_o,
               bus.ValidD_o, bus.MisalignF_o);
    end
    step(0, 0, 0, 0, 0, 0);
    total++;
    if (bus.InstrD_o !== 32'h0050_0093 || bus.PCD_o !== 32'h0 ||
        bus.PCPlus4D_o !== 32'h4 || bus.ValidD_o !== 1'b1) begin
      bad++;
      $display("FAIL first_fetch: got instr=%h pcd=%h pc4=%h v=%b want 00500093/0/4/1",
               bus.InstrD_o, bus.PCD_o, bus.PCPlus4D_o, bus.ValidD_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if (observed() !== expected() || bus.PCD_o !== bus.PCF_o - 32'd4 ||
          bus.ValidD_o !== 1'b1) begin
        bad++;
        $display("FAIL free_run[%0d]: got %h want %h", i, observed(), expected());
      end
    end
    $display("test_free_run done");
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 0, 0);
      total++;
      if (bus.PCF_o !== 32'h8 || bus.PCD_o !== 32'h4 || observed() !== expected()) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pcf=%h pcd=%h want 8/4", i, bus.PCF_o, bus.PCD_o);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    total++;
    if (bus.PCF_o !== 32'hC || bus.PCD_o !== 32'h8 || observed() !== expected()) begin
      bad++;
      $display("FAIL stall_release: got pcf=%h pcd=%h want c/8", bus.PCF_o, bus.PCD_o);
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect_flush();
    step(0, 1, 0, 1, 1, 32'h40);
    total++;
    if (bus.PCF_o !== 32'h40 || bus.InstrD_o !== NOP || bus.ValidD_o !== 1'b0 ||
        observed() !== expected()) begin
      bad++;
      $display("FAIL redirect_flush: got pcf=%h instr=%h v=%b want 40/13/0",
               bus.PCF_o, bus.InstrD_o, bus.ValidD_o);
    end
    step(0, 0, 0, 0, 0, 0);
    total++;
    if (bus.PCD_o !== 32'h40 || bus.InstrD_o !== rom_word(32'h40) || bus.ValidD_o !== 1'b1) begin
      bad++;
      $display("FAIL redirect_follow: got pcd=%h v=%b want 40/1", bus.PCD_o, bus.ValidD_o);
    end
    $display("test_redirect_flush done");
  endtask

  task automatic test_flush_wrap();
    step(0, 0, 1, 1, 1, 32'hFFFF_FFFC);
    total++;
    if (bus.ValidD_o !== 1'b0 || bus.InstrD_o !== NOP || bus.PCD_o !== 32'h0 ||
        bus.PCF_o !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL flush_over_stall: got v=%b instr=%h pcd=%h pcf=%h",
               bus.ValidD_o, bus.InstrD_o, bus.PCD_o, bus.PCF_o);
    end
    step(0, 0, 0, 0, 0, 0);
    total++;
    if (bus.PCF_o !== 32'h0 || bus.PCD_o !== 32'hFFFF_FFFC || bus.PCPlus4D_o !== 32'h0 ||
        bus.MisalignF_o !== 1'b0 || observed() !== expected()) begin
      bad++;
      $display("FAIL pc_wrap: got pcf=%h pcd=%h pc4=%h mis=%b want 0/fffffffc/0/0",
               bus.PCF_o, bus.PCD_o, bus.PCPlus4D_o, bus.MisalignF_o);
    end
    $display("test_flush_wrap done");
  endtask

  task automatic test_misalign();
    step(0, 0, 0, 1, 1, 32'h0000_0046);
    total++;
    if (bus.PCF_o !== 32'h44 || bus.MisalignF_o !== 1'b1) begin
      bad++;
      $display("FAIL misalign_set: got pcf=%h mis=%b want 44/1", bus.PCF_o, bus.MisalignF_o);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, (i == 2), 32'h100);
      total++;
      if (bus.MisalignF_o !== 1'b1 || observed() !== expected()) begin
        bad++;
        $display("FAIL misalign_sticky[%0d]: got %h want %h", i, observed(), expected());
      end
    end
    step(1, 0, 0, 0, 0, 0);
    total++;
    if (bus.MisalignF_o !== 1'b0 || bus.PCF_o !== 32'h0) begin
      bad++;
      $display("FAIL misalign_clear: got mis=%b pcf=%h want 0/0", bus.MisalignF_o, bus.PCF_o);
    end
    $display("test_misalign done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, sf, sd, fl, src;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 49) == 0);
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      src = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      step(r, sf, sd, fl, src, tgt);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, observed(), expected());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    bus.StallF_i = 0; bus.StallD_i = 0; bus.FlushD_i = 0;
    bus.PCSrcE_i = 0; bus.PCTargetE_i = 0;
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_flush();
    test_flush_wrap();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
